log_div_32bit_pipe: RTL and testbench
=====================================

LOG_DIV_32BIT_PIPE -- requirements
Module: log_div_32bit_pipe

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-result counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  an operand pair is presented.
REQ-005 Port: in_ready  output  1  block accepts the operand pair this cycle.
REQ-006 Port: in_x  input  32  unsigned dividend.
REQ-007 Port: in_y  input  32  unsigned divisor.
REQ-008 Port: out_valid  output  1  a result is presented.
REQ-009 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-010 Port: out_q  output  32  approximate unsigned quotient.
REQ-011 Port: out_dz  output  1  divide-by-zero flag for out_q.
REQ-012 Port: done_cnt  output  CNT_W  count of results accepted downstream; saturating.

Function
REQ-013 Algorithm: Mitchell logarithmic divider, the inverse of the team's logarithmic multiplier.
REQ-014 Exponents and fractions: kx, ky = leading-one positions of x, y; Fx = (x << (31-kx)) with bit 31 cleared (31-bit fraction); Fy likewise.
REQ-015 Fraction difference: d = Fx - Fy, signed.
REQ-016 Mantissa and exponent, d >= 0: M = 2^31 + d, e = kx - ky.
REQ-017 Mantissa and exponent, d < 0: M = 2^32 + d, e = kx - ky - 1.
REQ-018 Quotient: q = M >> (31-e) when e >= 0; q = 0 when e < 0; M fits 32 bits, so no overflow occurs.
REQ-019 Zero divisor: y == 0 gives q = 32'hFFFFFFFF and dz = 1; this overrides REQ-020.
REQ-020 Zero dividend: x == 0 with y != 0 gives q = 0 and dz = 0.
REQ-021 Power-of-two divisor: when y is a power of two, q equals x >> ky exactly, with no approximation error.
REQ-022 Pipeline structure: three register stages.
  - S1: leading-one detect and encode, fraction extract, zero flags.
  - S2: subtract, select M and e.
  - S3: shift, special-case override; drives out_q and out_dz.
REQ-023 Pipeline advance: all stage registers, including their valid bits, load only when adv = ~out_valid | out_ready.
REQ-024 Input handshake: in_ready = adv, combinational.
REQ-025 Input transfer: a transfer occurs when in_valid & in_ready; otherwise a bubble (valid = 0) enters S1 on adv.
REQ-026 Latency and throughput: the result appears on out_valid exactly 3 adv cycles after input transfer; throughput is 1 per cycle when out_ready stays high.
REQ-027 Stall: while out_valid & ~out_ready, out_q, out_dz and every stage register are held; results are neither lost nor duplicated.
REQ-028 Ordering: results emerge in input order.
REQ-029 Counter: done_cnt increments on out_valid & out_ready and saturates at 2^CNT_W - 1.
REQ-030 Simultaneous stall release: an input accepted in the same cycle that out_ready releases a stall is accepted and processed normally.

Reset
REQ-031 Reset values: on rst_n low, all stage valid bits = 0, out_valid = 0, out_q = 0, out_dz = 0, done_cnt = 0, asynchronously.
REQ-032 Reset mid-operation: in-flight operations are discarded; no output appears for them after reset.
REQ-033 Reset release: in_ready = 1 in the first cycle after rst_n deasserts.

Verification
REQ-034 Power-of-two divisor: x=100, y=4, out_ready=1 -> out_valid 3 cycles later, out_q=25, out_dz=0.
REQ-035 Approximation cases, one per line:
  - x=10, y=3 -> out_q=3 (d<0 path, e=1).
  - x=12, y=3 -> out_q=4.
  - x=3, y=10 -> out_q=0 (e<0).
REQ-036 Special cases, one per line:
  - x=5, y=0 -> out_q=32'hFFFFFFFF, out_dz=1.
  - x=0, y=7 -> out_q=0, out_dz=0.
  - x=32'hFFFFFFFF, y=1 -> out_q=32'hFFFFFFFF, out_dz=0.
REQ-037 Back-to-back throughput: 8 consecutive inputs with out_ready=1 -> 8 consecutive out_valid cycles in order; done_cnt=8.
REQ-038 Backpressure: out_ready=0 once the first result is valid -> in_ready=0 and out_q held stable for 5 cycles; on out_ready=1 all queued results drain in order with none lost.
REQ-039 Reset mid-operation: rst_n pulsed low with 2 operations in flight -> out_valid=0 and done_cnt=0 immediately; no stale result after release.

Source files
------------

// File: rtl/log_div_32bit_pipe.sv
// log_div_32bit_pipe: three-stage Mitchell logarithmic divider with valid/ready handshake
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; in_ready follows pipeline advance
//   in_x, in_y           unsigned dividend and divisor
//   out_valid/out_ready  result handshake
//   out_q, out_dz        approximate quotient and divide-by-zero flag
//   done_cnt             saturating count of results taken downstream
module log_div_32bit_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [31:0]      in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_q,
   output logic             out_dz,
   output logic [CNT_W-1:0] done_cnt
);
   logic               adv;
   logic [4:0]         kx, ky;
   logic [30:0]        fx, fy;
   logic               v1, xz1, yz1;
   logic [4:0]         kx1, ky1;
   logic [30:0]        fx1, fy1;
   logic [31:0]        d, m;
   logic               neg;
   logic signed [6:0]  e;
   logic               v2, xz2, yz2;
   logic [31:0]        m2;
   logic signed [6:0]  e2;
   logic [31:0]        q;
   // The whole pipeline moves as one unit; a held output freezes every stage.
   assign adv = ~out_valid | out_ready;
   assign in_ready = adv;
   // Leading-one position; the last set bit scanned upward wins.
   always_comb begin
      kx = '0;
      ky = '0;
      for (int i = 0; i < 32; i++) begin
         if (in_x[i]) kx = 5'(i);
         if (in_y[i]) ky = 5'(i);
      end
      fx = 31'(in_x << (5'd31 - kx));
      fy = 31'(in_y << (5'd31 - ky));
   end
   // A negative difference borrows from the exponent: 2^32 + d is just d read unsigned.
   always_comb begin
      d = {1'b0, fx1} - {1'b0, fy1};
      neg = d[31];
      m = neg ? d : {1'b1, d[30:0]};
      e = $signed({2'b00, kx1}) - $signed({2'b00, ky1}) - $signed({6'd0, neg});
   end
   always_comb begin
      q = (e2 < 7'sd0) ? '0 : m2 >> (5'd31 - e2[4:0]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         xz1 <= 1'b0;
         yz1 <= 1'b0;
         kx1 <= '0;
         ky1 <= '0;
         fx1 <= '0;
         fy1 <= '0;
      end else if (adv) begin
         v1 <= in_valid;
         xz1 <= ~|in_x;
         yz1 <= ~|in_y;
         kx1 <= kx;
         ky1 <= ky;
         fx1 <= fx;
         fy1 <= fy;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0;
         xz2 <= 1'b0;
         yz2 <= 1'b0;
         m2 <= '0;
         e2 <= '0;
      end else if (adv) begin
         v2 <= v1;
         xz2 <= xz1;
         yz2 <= yz1;
         m2 <= m;
         e2 <= e;
      end
   end
   // Zero divisor outranks zero dividend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_q <= '0;
         out_dz <= 1'b0;
      end else if (adv) begin
         out_valid <= v2;
         out_q <= yz2 ? '1 : xz2 ? '0 : q;
         out_dz <= yz2;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_cnt <= '0;
      else if (out_valid & out_ready & ~&done_cnt) done_cnt <= done_cnt + 1'b1;
   end
endmodule

// File: tb/tb_log_div_32bit_pipe.sv
// tb_log_div_32bit_pipe: directed self-checking bench for log_div_32bit_pipe
module tb_log_div_32bit_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = '0;
   logic [31:0] in_y = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_q;
   logic        out_dz;
   logic [15:0] done_cnt;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_out = 0;
   int          run = 0;
   int          max_run = 0;
   int          n_out_snap;
   logic [32:0] exp_q[$];
   logic [32:0] e;
   log_div_32bit_pipe #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
      .out_q(out_q), .out_dz(out_dz), .done_cnt(done_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] q, input logic dz);
      in_valid = 1'b1;
      in_x = x;
      in_y = y;
      chk("in_ready_send", in_ready, 1);
      if (in_ready) exp_q.push_back({dz, q});
      tick();
      in_valid = 1'b0;
   endtask
   // Result monitor: every accepted result must match the next expected one in order.
   always @(negedge clk) begin
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         chk("result_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_q", out_q, e[31:0]);
            chk("out_dz", out_dz, e[32]);
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_q", out_q, 0);
      chk("rst_out_dz", out_dz, 0);
      chk("rst_done_cnt", done_cnt, 0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("in_ready_after_rst", in_ready, 1);
      // Latency: power-of-two divisor appears after exactly three edges.
      send(32'd100, 32'd4, 32'd25, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_not_yet", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
      chk("lat_q", out_q, 25);
      tick();
      tick();
      max_run = 0;
      // Back-to-back stream covering approximation and special cases.
      send(32'd10, 32'd3, 32'd3, 1'b0);
      send(32'd12, 32'd3, 32'd4, 1'b0);
      send(32'd3, 32'd10, 32'd0, 1'b0);
      send(32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
      send(32'd0, 32'd7, 32'd0, 1'b0);
      send(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
      send(32'd100, 32'd4, 32'd25, 1'b0);
      send(32'd7, 32'd7, 32'd1, 1'b0);
      repeat (5) tick();
      chk("stream_run", max_run, 8);
      chk("stream_drained", exp_q.size(), 0);
      chk("stream_done_cnt", done_cnt, 9);
      // Backpressure: fill the pipe, stall, then release while a new input waits.
      out_ready = 1'b0;
      send(32'd12, 32'd3, 32'd4, 1'b0);
      send(32'd10, 32'd3, 32'd3, 1'b0);
      send(32'd100, 32'd4, 32'd25, 1'b0);
      in_valid = 1'b1;
      in_x = 32'd3;
      in_y = 32'd10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_valid", out_valid, 1);
         chk("stall_q", out_q, 4);
      end
      tick();
      out_ready = 1'b1;
      exp_q.push_back({1'b0, 32'd0});
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      chk("bp_drained", exp_q.size(), 0);
      chk("bp_done_cnt", done_cnt, 13);
      // Reset with two operations in flight.
      send(32'd10, 32'd3, 32'd3, 1'b0);
      send(32'd12, 32'd3, 32'd4, 1'b0);
      chk("pre_rst_valid", out_valid, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_done_cnt", done_cnt, 0);
      exp_q.delete();
      n_out_snap = n_out;
      tick();
      tick();
      rst_n = 1'b1;
      chk("in_ready_rel", in_ready, 1);
      repeat (6) tick();
      chk("no_stale_out", n_out, n_out_snap);
      chk("post_rst_done_cnt", done_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
